// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with framing/parity checks and a valid/ready receive FIFO
module ps2_rx_fifo #(
  parameter int SYNC_STAGES    = 3,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                        clk,
  input  logic                        clrn,
  input  logic                        ps2_clk,
  input  logic                        ps2_data,
  input  logic                        rd_ready,
  output logic                        rd_valid,
  output logic [7:0]                  rd_data,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow,
  output logic                        parity_err,
  output logic                        frame_err,
  input  logic                        ovf_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic [3:0]             cnt;
  logic [9:0]             shreg;
  logic [TW-1:0]          tcnt;
  logic [7:0]             mem [FIFO_DEPTH];
  logic [AW:0]            wr_ptr, rd_ptr;
  logic [10:0]            frame;
  logic fall, sample, last_bit, framing_ok, parity_ok, good, timeout, full, push, pop;
  assign fall       = clk_sync[SYNC_STAGES-1] & ~clk_sync[SYNC_STAGES-2];
  assign sample     = data_sync[SYNC_STAGES-1];
  assign last_bit   = fall && cnt == 4'd10;
  assign frame      = {sample, shreg};
  assign framing_ok = !frame[0] && frame[10];
  assign parity_ok  = ^frame[9:1];
  assign good       = framing_ok && parity_ok;
  assign timeout    = !fall && cnt != 4'd0 && tcnt == TW'(TIMEOUT_CYCLES - 1);
  assign level      = wr_ptr - rd_ptr;
  assign full       = level == (AW+1)'(FIFO_DEPTH);
  assign rd_valid   = |level;
  assign rd_data    = rd_valid ? mem[rd_ptr[AW-1:0]] : 8'd0;
  assign pop        = rd_valid && rd_ready;
  assign push       = last_bit && good && (!full || pop);
  // Pin synchronisers, idle-high so reset never fakes a falling edge
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
    end
  // Bit framing: LSB-first shift, wrap after 11 edges, abandon a stalled partial frame
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      cnt   <= 4'd0;
      shreg <= '0;
      tcnt  <= '0;
    end else begin
      if (fall) begin
        cnt   <= last_bit ? 4'd0 : cnt + 4'd1;
        shreg <= {sample, shreg[9:1]};
      end else if (timeout) cnt <= 4'd0;
      tcnt <= (fall || timeout || cnt == 4'd0) ? '0 : tcnt + 1'b1;
    end
  // Error pulses, sticky overflow (a drop beats a same-cycle clear) and FIFO pointers
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overflow   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      frame_err  <= (last_bit && !framing_ok) || timeout;
      parity_err <= last_bit && framing_ok && !parity_ok;
      overflow   <= (last_bit && good && full && !pop) || (overflow && !ovf_clr);
      wr_ptr     <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr     <= pop ? rd_ptr + 1'b1 : rd_ptr;
    end
  // FIFO storage needs no reset: rd_data is masked while empty
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= frame[8:1];
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed PS/2 frames checked against a queue-based receiver model every cycle
module tb_ps2_rx_fifo;
  localparam int S = 3;
  localparam int D = 8;
  localparam int TO = 100;
  localparam int H = 4;
  logic clk = 0, clrn = 0, ps2_clk = 1, ps2_data = 1, rd_ready = 0, ovf_clr = 0;
  logic rd_valid, overflow, parity_err, frame_err;
  logic [7:0] rd_data;
  logic [$clog2(D):0] level;
  int checks = 0, errors = 0;
  int cyc = 0, last_fall = 0, rise_cyc = 0, pe_seen = 0, fe_seen = 0;
  logic prev_rv = 0;
  logic [7:0] q[$];
  bit bq[$];
  int idle = 0;
  logic m_ovf = 0, m_pe = 0, m_fe = 0;
  logic [7:0] hc = '1, hd = '1;

  ps2_rx_fifo #(.SYNC_STAGES(S), .FIFO_DEPTH(D), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .level(level), .overflow(overflow),
    .parity_err(parity_err), .frame_err(frame_err), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Receiver model: a pin level reaches the framing logic S-1 clocks after it is first sampled
  initial forever begin
    @(posedge clk or negedge clrn);
    if (!clrn) begin
      q.delete(); bq.delete(); idle = 0;
      m_ovf = 0; m_pe = 0; m_fe = 0; hc = '1; hd = '1;
    end else begin
      logic fall, good, do_pop;
      logic [7:0] b;
      bit par;
      fall = hc[S-2] == 1'b0 && hc[S-1] == 1'b1;
      good = 0; m_pe = 0; m_fe = 0; b = 0;
      do_pop = q.size() > 0 && rd_ready;
      if (fall) begin
        idle = 0;
        bq.push_back(hd[S-1]);
        if (bq.size() == 11) begin
          par = 0;
          for (int i = 1; i <= 9; i++) par ^= bq[i];
          for (int i = 0; i < 8; i++) b[i] = bq[i+1];
          if (bq[0] != 0 || bq[10] != 1) m_fe = 1;
          else if (!par) m_pe = 1;
          else good = 1;
          bq.delete();
        end
      end else if (bq.size() > 0) begin
        idle++;
        if (idle == TO) begin
          m_fe = 1;
          bq.delete();
        end
      end
      if (good && q.size() == D && !do_pop) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      if (do_pop) void'(q.pop_front());
      if (good && (q.size() < D)) q.push_back(b);
      hc = {hc[6:0], ps2_clk};
      hd = {hd[6:0], ps2_data};
    end
  end

  // Per-cycle comparison, sampled well clear of both clock edges
  initial forever begin
    @(posedge clk);
    #3;
    chk("rd_valid", rd_valid, q.size() > 0);
    chk("level", level, q.size());
    if (q.size() > 0) chk("rd_data", rd_data, q[0]);
    chk("overflow", overflow, m_ovf);
    chk("parity_err", parity_err, m_pe);
    chk("frame_err", frame_err, m_fe);
    pe_seen += parity_err;
    fe_seen += frame_err;
    if (rd_valid && !prev_rv) rise_cyc = cyc;
    prev_rv = rd_valid;
  end

  // mode 0: plain, 1: rd_ready on the push cycle, 2: ovf_clr on the push cycle
  task automatic send(input logic [7:0] b, input int nbits, input bit bad_par,
                      input bit start, input bit stop, input int mode);
    logic [10:0] f;
    f = {stop, (~^b) ^ bad_par, b, start};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      tick(H);
      ps2_clk = 0;
      last_fall = cyc;
      if (i == 10 && mode != 0) begin
        tick(2);
        if (mode == 1) rd_ready = 1; else ovf_clr = 1;
        tick(1);
        rd_ready = 0; ovf_clr = 0;
        tick(1);
      end else tick(H);
      ps2_clk = 1;
    end
    ps2_data = 1;
    tick(3 * H);
  endtask

  task automatic pop1;
    rd_ready = 1;
    tick(1);
    rd_ready = 0;
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_parity_err"}, parity_err, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
  endtask

  initial begin
    logic [7:0] seq [4];
    int pe0, fe0, k;
    seq = '{8'hF0, 8'h1C, 8'hE0, 8'h75};
    tick(3);
    reset_vals("reset");
    clrn = 1;
    tick(5);
    send(8'h1C, 11, 0, 0, 1, 0);
    chk("t1_valid", rd_valid, 1);
    chk("t1_data", rd_data, 8'h1C);
    chk("t1_level", level, 1);
    chk("t1_latency", rise_cyc - last_fall, S);
    chk("t1_no_err", pe_seen + fe_seen, 0);
    pop1();
    chk("t1_empty", level, 0);
    for (int i = 0; i < 4; i++) send(seq[i], 11, 0, 0, 1, 0);
    chk("t2_level", level, 4);
    chk("t2_head", rd_data, 8'hF0);
    rd_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      chk("t2_pop_level", level, 4 - i);
      if (i < 4) chk("t2_pop_data", rd_data, seq[i]);
    end
    rd_ready = 0;
    chk("t2_valid_low", rd_valid, 0);
    pe0 = pe_seen;
    send(8'h1C, 11, 1, 0, 1, 0);
    chk("t3_pe_pulses", pe_seen - pe0, 1);
    chk("t3_level", level, 0);
    send(8'h1C, 11, 0, 0, 1, 0);
    chk("t3_good_data", rd_data, 8'h1C);
    pop1();
    fe0 = fe_seen;
    send(8'h1C, 11, 0, 0, 0, 0);
    send(8'h1C, 11, 0, 1, 1, 0);
    chk("t4_fe_pulses", fe_seen - fe0, 2);
    chk("t4_level", level, 0);
    send(8'h1C, 11, 0, 0, 1, 0);
    chk("t4_resync_data", rd_data, 8'h1C);
    pop1();
    send(8'h5A, 5, 0, 0, 1, 0);
    k = 0;
    while (!frame_err && k < 400) begin tick(1); k++; end
    chk("t5_timeout_at", cyc - last_fall, TO + S);
    send(8'h5A, 11, 0, 0, 1, 0);
    chk("t5_data", rd_data, 8'h5A);
    chk("t5_level", level, 1);
    pop1();
    for (int i = 0; i < D; i++) send(8'h10 + 8'(i), 11, 0, 0, 1, 0);
    chk("t6_full", level, D);
    send(8'h99, 11, 0, 0, 1, 0);
    chk("t6_ovf", overflow, 1);
    chk("t6_level", level, D);
    chk("t6_head", rd_data, 8'h10);
    ovf_clr = 1;
    tick(1);
    ovf_clr = 0;
    chk("t6_ovf_clr", overflow, 0);
    send(8'hA0, 11, 0, 0, 1, 1);
    chk("t6_pop_push_ovf", overflow, 0);
    chk("t6_pop_push_level", level, D);
    chk("t6_pop_push_head", rd_data, 8'h11);
    send(8'hA1, 11, 0, 0, 1, 2);
    chk("t6_set_wins", overflow, 1);
    send(8'h33, 4, 0, 0, 1, 0);
    clrn = 0;
    tick(1);
    reset_vals("midreset");
    tick(2);
    clrn = 1;
    tick(2 * TO);
    chk("t7_no_stray_err", frame_err, 0);
    send(8'h1C, 11, 0, 0, 1, 0);
    chk("t7_level", level, 1);
    chk("t7_data", rd_data, 8'h1C);
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
- Parametrised PS/2 device-to-host receiver with a receive FIFO and a valid/ready read port.
- Takes the raw ps2_clk/ps2_data pins, frames 11-bit packets, and checks start, stop and odd parity.
- Good bytes are queued; errors and FIFO overflow are reported on flags.
- Sits between the keyboard pins and the scan-code decoder / display logic.

Parameters:
SYNC_STAGES, 3, flops in each pin synchroniser (>=2).
FIFO_DEPTH, 8, receive FIFO entries (power of 2, >=2).
TIMEOUT_CYCLES, 50000, clk cycles with no ps2_clk falling edge before a partial frame is abandoned (>=16).

Ports:
clk  in  1  system clock.
clrn  in  1  asynchronous active-low reset.
ps2_clk  in  1  raw PS/2 clock pin (asynchronous).
ps2_data  in  1  raw PS/2 data pin (asynchronous).
rd_ready  in  1  consumer accepts the head byte this cycle.
rd_valid  out  1  FIFO non-empty.
rd_data  out  8  FIFO head byte; valid only while rd_valid=1.
level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
overflow  out  1  sticky: a good frame was dropped because the FIFO was full.
parity_err  out  1  one-cycle pulse: frame had bad odd parity.
frame_err  out  1  one-cycle pulse: bad start/stop bit, or timeout.
ovf_clr  in  1  clears overflow (synchronous).

Behaviour:
- Reset (clrn=0, async):
  - Synchroniser flops go to 1 (idle-high bus).
  - Bit counter, timeout counter and FIFO pointers go to 0.
  - rd_valid=0, rd_data=0, level=0, overflow=0, parity_err=0, frame_err=0.
  - A partial frame is discarded. No frame is completed until a fresh start bit arrives after release.
- Synchronisation:
  - ps2_clk and ps2_data each pass through SYNC_STAGES flops.
  - A falling edge is detected when the last stage is 1 and the previous stage is 0.
  - Data is sampled from the synchronised ps2_data on the edge-detect cycle.
- Framing: a 4-bit counter cnt runs 0..10, shifting the sample into bit position cnt.
  - On the 11th edge (cnt==10), evaluate bits [10:0] (bit 10 is the current sample).
  - A frame is good when start==0, stop==1, and XOR of data[7:0] and parity is 1.
  - cnt returns to 0 on every 11th edge, good or bad.
- Error priority:
  - Start or stop bit wrong: frame_err pulses; parity_err stays 0.
  - Otherwise, parity wrong: parity_err pulses.
  - Bad frames are never pushed.
- Push latency: byte appears at the FIFO head with rd_valid=1 on the cycle after the 11th-edge cycle.
- FIFO:
  - Circular buffer with pointers one bit wider than the address, to separate full from empty.
  - Pop occurs when rd_valid && rd_ready; rd_ready while empty is ignored.
  - Full with a good frame and no pop in the same cycle: byte is dropped, overflow is set, level stays FIFO_DEPTH.
  - Full with a good frame and a pop in the same cycle: both happen, no overflow, level unchanged.
  - Empty: a push with rd_ready=1 is not bypassed; the byte becomes visible the next cycle.
- overflow:
  - Cleared by ovf_clr=1.
  - If a drop and ovf_clr occur in the same cycle, set wins.
- Timeout:
  - While cnt!=0, a counter increments each clk and resets on each falling edge.
  - On reaching TIMEOUT_CYCLES: cnt returns to 0, frame_err pulses once, and the partial frame is dropped.
  - The counter is held at 0 while cnt==0.
- Glitches: a ps2_clk low pulse shorter than one clk period may be missed; this is defined as acceptable.

Test Plan:
- Send 0x1C (start 0, data LSB first, parity 0, stop 1) -> rd_valid rises one cycle after the 11th edge; rd_data=0x1C; level=1; no error pulses.
- Send the sequence F0, 1C, E0, 75 with rd_ready=0, then hold rd_ready=1 -> bytes pop in order F0, 1C, E0, 75; level steps 4,3,2,1,0; rd_valid falls after the 4th pop.
- Send 0x1C with parity bit 1 -> exactly one parity_err pulse, FIFO unchanged; then send a good 0x1C -> accepted normally.
- Send a frame with stop bit 0, then a frame with start bit 1 -> each gives one frame_err pulse, no push, and cnt resyncs so the next good frame is received.
- With TIMEOUT_CYCLES=100, send 5 bits then idle -> frame_err pulses at cycle 100 after the last edge; the next full frame 0x5A is received correctly.
- Fill the FIFO with 8 bytes, send a 9th -> overflow=1, level=8, head still the first byte. Repeat with rd_ready=1 on the 9th frame's push cycle -> no overflow. Pulse ovf_clr -> overflow=0. Assert clrn mid-frame -> all outputs return to reset values.
